// File: rtl/instr_prefetch.sv
// Instruction-fetch front end: issues word requests on req/gnt/rvalid, keeps up to
// two in flight, buffers responses in a 2-entry FIFO and feeds the realign buffer.
package riscv_defines;
  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_ADDR_WIDTH = 32;
endpackage

module instr_prefetch
  import riscv_defines::*;
#(
  parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR       = 32'h0000_0080,
  parameter int                          MAX_OUTSTANDING = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_enable_i,
  input  logic                        branch_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] branch_addr_i,
  output logic                        instr_req_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                        instr_gnt_i,
  input  logic                        instr_rvalid_i,
  input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
  output logic                        buf_clear_o,
  output logic                        buf_read_offset_o,
  output logic                        buf_write_en_o,
  output logic [RISCV_WORD_WIDTH-1:0] buf_instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] buf_addr_o,
  input  logic                        buf_full_i,
  output logic                        busy_o
);

  localparam int AW    = RISCV_ADDR_WIDTH;
  localparam int WW    = RISCV_WORD_WIDTH;
  localparam int DEPTH = MAX_OUTSTANDING;
  localparam logic [AW-1:0] BOOT_FETCH = {BOOT_ADDR[AW-1:2], 2'b00};

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, STALL = 2'd2} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   fetch_addr_reg, fetch_addr_next;
  logic [1:0]      outstanding_reg, outstanding_next;
  logic [1:0]      discard_reg, discard_next;
  logic [1:0]      fifo_count_reg, fifo_count_next;
  logic            clear_reg, clear_next;
  logic            offset_reg, offset_next;
  logic            boot_offset_reg, boot_offset_next;
  logic            req_hold_reg;
  logic            infl_wr_reg, infl_rd_reg;
  logic            fifo_wr_reg, fifo_rd_reg;

  logic [AW-1:0]   infl_addr [DEPTH];
  logic [WW-1:0]   fifo_data [DEPTH];
  logic [AW-1:0]   fifo_addr [DEPTH];

  logic            grant, resp, push, pop;
  logic [2:0]      credit_used;
  logic [AW-1:0]   branch_target;
  logic            unused_bits;

  assign unused_bits   = branch_addr_i[0];
  assign branch_target = {branch_addr_i[AW-1:2], 2'b00};

  // Stray rvalid with nothing in flight (e.g. right after reset) is ignored.
  assign grant = instr_req_o & instr_gnt_i;
  assign resp  = instr_rvalid_i & (outstanding_reg != 2'd0);
  assign push  = resp & (discard_reg == 2'd0) & ~branch_i;
  assign pop   = buf_write_en_o;

  // A word leaving the FIFO this cycle frees its slot; that keeps 1 word/cycle.
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg} - {2'b00, pop};

  assign instr_req_o       = req_hold_reg | ((state_reg == FETCH) & (credit_used < 3'(DEPTH)));
  assign instr_addr_o      = fetch_addr_reg;
  assign buf_write_en_o    = (fifo_count_reg != 2'd0) & ~buf_full_i & ~clear_reg;
  assign buf_instr_o       = fifo_data[fifo_rd_reg];
  assign buf_addr_o        = fifo_addr[fifo_rd_reg];
  assign buf_clear_o       = clear_reg;
  assign buf_read_offset_o = offset_reg;
  assign busy_o            = (outstanding_reg != 2'd0) | (fifo_count_reg != 2'd0);

  always_comb begin
    state_next       = state_reg;
    clear_next       = 1'b0;
    offset_next      = offset_reg;
    boot_offset_next = boot_offset_reg;
    fetch_addr_next  = fetch_addr_reg;
    outstanding_next = outstanding_reg + {1'b0, grant} - {1'b0, resp};
    discard_next     = discard_reg;
    fifo_count_next  = fifo_count_reg + {1'b0, push} - {1'b0, pop};

    case (state_reg)
      IDLE: begin
        if (fetch_enable_i) begin
          state_next  = FETCH;
          clear_next  = 1'b1;
          offset_next = boot_offset_reg;
        end
      end
      FETCH:   if (!fetch_enable_i) state_next = STALL;
      STALL:   if (fetch_enable_i) state_next = FETCH;
      default: state_next = IDLE;
    endcase

    if (grant) fetch_addr_next = fetch_addr_reg + AW'(4);
    if (resp && (discard_reg != 2'd0)) discard_next = discard_reg - 2'd1;

    // Redirect: everything still in flight, including this cycle's grant, is stale.
    if (branch_i) begin
      clear_next       = 1'b1;
      offset_next      = branch_addr_i[1];
      boot_offset_next = branch_addr_i[1];
      fetch_addr_next  = branch_target;
      discard_next     = outstanding_next;
      fifo_count_next  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      fetch_addr_reg  <= BOOT_FETCH;
      outstanding_reg <= 2'd0;
      discard_reg     <= 2'd0;
      fifo_count_reg  <= 2'd0;
      clear_reg       <= 1'b0;
      offset_reg      <= 1'b0;
      boot_offset_reg <= BOOT_ADDR[1];
      req_hold_reg    <= 1'b0;
      infl_wr_reg     <= 1'b0;
      infl_rd_reg     <= 1'b0;
      fifo_wr_reg     <= 1'b0;
      fifo_rd_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fetch_addr_reg  <= fetch_addr_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      fifo_count_reg  <= fifo_count_next;
      clear_reg       <= clear_next;
      offset_reg      <= offset_next;
      boot_offset_reg <= boot_offset_next;
      req_hold_reg    <= instr_req_o & ~instr_gnt_i;
      // Single-bit pointers: both queues are exactly two entries deep.
      if (grant) infl_wr_reg <= ~infl_wr_reg;
      if (resp)  infl_rd_reg <= ~infl_rd_reg;
      if (push)  fifo_wr_reg <= ~fifo_wr_reg;
      if (branch_i)  fifo_rd_reg <= fifo_wr_reg;
      else if (pop)  fifo_rd_reg <= ~fifo_rd_reg;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [AW-1:0] infl_addr_reg;
    logic [WW-1:0] data_reg;
    logic [AW-1:0] addr_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        infl_addr_reg <= '0;
        data_reg      <= '0;
        addr_reg      <= '0;
      end else begin
        if (grant && (infl_wr_reg == 1'(gi))) infl_addr_reg <= fetch_addr_reg;
        if (push && (fifo_wr_reg == 1'(gi))) begin
          data_reg <= instr_rdata_i;
          addr_reg <= infl_addr[infl_rd_reg];
        end
      end
    end

    assign infl_addr[gi] = infl_addr_reg;
    assign fifo_data[gi] = data_reg;
    assign fifo_addr[gi] = addr_reg;
  end

  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(resp && (discard_reg == 2'd0) && (fifo_count_reg == 2'(DEPTH))));

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: a 1-cycle memory model feeds a scoreboard of
// expected buffer writes, request addresses and clear pulses.
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_enable_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        buf_clear_o;
  logic        buf_read_offset_o;
  logic        buf_write_en_o;
  logic [31:0] buf_instr_o;
  logic [31:0] buf_addr_o;
  logic        buf_full_i;
  logic        busy_o;

  always #5 clk = ~clk;

  instr_prefetch dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_enable_i    (fetch_enable_i),
    .branch_i          (branch_i),
    .branch_addr_i     (branch_addr_i),
    .instr_req_o       (instr_req_o),
    .instr_addr_o      (instr_addr_o),
    .instr_gnt_i       (instr_gnt_i),
    .instr_rvalid_i    (instr_rvalid_i),
    .instr_rdata_i     (instr_rdata_i),
    .buf_clear_o       (buf_clear_o),
    .buf_read_offset_o (buf_read_offset_o),
    .buf_write_en_o    (buf_write_en_o),
    .buf_instr_o       (buf_instr_o),
    .buf_addr_o        (buf_addr_o),
    .buf_full_i        (buf_full_i),
    .busy_o            (busy_o)
  );

  typedef struct {logic [31:0] addr; logic stale;} mreq_t;
  typedef struct {logic [31:0] data; logic [31:0] addr;} wr_t;

  mreq_t       mem_q[$];
  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_grants, n_writes, base;
  logic [31:0] exp_fetch, cur_addr, first_wr_addr, last_wr_addr;
  logic        exp_clear, exp_offset, boot_off, tb_idle, cur_stale, hold_resp;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1E0F};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_enable_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; buf_full_i = 1'b0;
    hold_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mem_q.delete(); exp_q.delete();
    exp_fetch = 32'h80; exp_clear = 1'b0; exp_offset = 1'b0; boot_off = 1'b0;
    tb_idle = 1'b1; cur_stale = 1'b0; cur_addr = '0;
    n_grants = 0; n_writes = 0; first_wr_addr = 'x; last_wr_addr = 'x;
  endtask

  // One clock cycle: check at the falling edge, then drive memory after the rising edge.
  task automatic cycle();
    wr_t   w;
    mreq_t m;
    logic  nclr, noff;
    @(negedge clk);
    chk("clear", buf_clear_o, exp_clear);
    if (exp_clear) chk("offset", buf_read_offset_o, exp_offset);
    chk("wr_en", buf_write_en_o, (exp_q.size() > 0) && !buf_full_i && !exp_clear);
    if (buf_write_en_o && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("wr_addr", buf_addr_o, w.addr);
      chk("wr_data", buf_instr_o, w.data);
      $display("write addr=%h data=%h", buf_addr_o, buf_instr_o);
      if (n_writes == 0) first_wr_addr = buf_addr_o;
      last_wr_addr = buf_addr_o;
      n_writes++;
    end
    if (instr_req_o && instr_gnt_i) begin
      chk("req_addr", instr_addr_o, exp_fetch);
      $display("grant addr=%h", instr_addr_o);
      mem_q.push_back('{addr: instr_addr_o, stale: 1'b0});
      exp_fetch = exp_fetch + 32'd4;
      n_grants++;
    end
    nclr = branch_i || (tb_idle && fetch_enable_i);
    noff = branch_i ? branch_addr_i[1] : boot_off;
    if (branch_i) begin
      $display("branch target=%h", branch_addr_i);
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_fetch = {branch_addr_i[31:2], 2'b00};
      boot_off  = branch_addr_i[1];
    end else if (instr_rvalid_i && !cur_stale) begin
      exp_q.push_back('{data: mem_word(cur_addr), addr: cur_addr});
    end
    if (tb_idle && fetch_enable_i) tb_idle = 1'b0;
    @(posedge clk);
    #1;
    exp_clear  = nclr;
    exp_offset = noff;
    if (!hold_resp && mem_q.size() > 0) begin
      m = mem_q.pop_front();
      instr_rvalid_i = 1'b1; instr_rdata_i = mem_word(m.addr);
      cur_addr = m.addr; cur_stale = m.stale;
    end else begin
      instr_rvalid_i = 1'b0; instr_rdata_i = '0; cur_stale = 1'b0;
    end
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_req", instr_req_o, 1'b0);
    chk("rst_addr", instr_addr_o, 32'h80);
    chk("rst_clear", buf_clear_o, 1'b0);
    chk("rst_offset", buf_read_offset_o, 1'b0);
    chk("rst_wr_en", buf_write_en_o, 1'b0);
    chk("rst_instr", buf_instr_o, 32'h0);
    chk("rst_baddr", buf_addr_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);

    // Boot stream, zero-wait memory
    instr_gnt_i = 1'b1; fetch_enable_i = 1'b1;
    repeat (12) cycle();
    chk("boot_grants", n_grants, 11);
    chk("boot_writes", n_writes, 9);
    chk("boot_first", first_wr_addr, 32'h80);

    // Backpressure from the start
    do_reset();
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_req", instr_req_o, 1'b0);
    buf_full_i = 1'b1; instr_gnt_i = 1'b1; fetch_enable_i = 1'b1;
    repeat (6) cycle();
    chk("bp_grants", n_grants, 2);
    chk("bp_req", instr_req_o, 1'b0);
    chk("bp_busy", busy_o, 1'b1);
    buf_full_i = 1'b0;
    repeat (3) cycle();
    chk("bp_writes", n_writes, 3);
    chk("bp_first", first_wr_addr, 32'h80);

    // Redirect with two requests in flight
    do_reset();
    hold_resp = 1'b1; instr_gnt_i = 1'b1; fetch_enable_i = 1'b1;
    repeat (3) cycle();
    chk("rd_busy", busy_o, 1'b1);
    branch_i = 1'b1; branch_addr_i = 32'h1002;
    cycle();
    branch_i = 1'b0; hold_resp = 1'b0;
    repeat (6) cycle();
    chk("rd_first", first_wr_addr, 32'h1000);

    // Redirect while a request waits for grant
    do_reset();
    instr_gnt_i = 1'b1; fetch_enable_i = 1'b1;
    repeat (5) cycle();
    instr_gnt_i = 1'b0;
    cycle();
    chk("ug_req", instr_req_o, 1'b1);
    chk("ug_addr", instr_addr_o, 32'h90);
    branch_i = 1'b1; branch_addr_i = 32'h200;
    cycle();
    branch_i = 1'b0;
    chk("ug_req_kept", instr_req_o, 1'b1);
    chk("ug_addr_new", instr_addr_o, 32'h200);
    instr_gnt_i = 1'b1;
    repeat (6) cycle();
    chk("ug_last", last_wr_addr, 32'h20C);

    // Stall and resume
    do_reset();
    instr_gnt_i = 1'b1; fetch_enable_i = 1'b1;
    repeat (6) cycle();
    fetch_enable_i = 1'b0; instr_gnt_i = 1'b0;
    cycle();
    chk("st_hold", instr_req_o, 1'b1);
    instr_gnt_i = 1'b1;
    cycle();
    base = n_grants;
    repeat (5) cycle();
    chk("st_no_grant", n_grants - base, 0);
    chk("st_req", instr_req_o, 1'b0);
    chk("st_busy", busy_o, 1'b0);
    chk("st_last", last_wr_addr, 32'h94);
    fetch_enable_i = 1'b1;
    base = n_grants;
    repeat (4) cycle();
    chk("st_resume", n_grants - base, 3);

    // Address wrap via redirect in IDLE
    do_reset();
    branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFF8;
    cycle();
    branch_i = 1'b0; fetch_enable_i = 1'b1; instr_gnt_i = 1'b1;
    repeat (6) cycle();
    chk("wrap_grants", n_grants, 5);
    chk("wrap_first", first_wr_addr, 32'hFFFF_FFF8);
    chk("wrap_last", last_wr_addr, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
